mio_bus_arb: RTL and testbench
==============================

MIO_BUS_ARB -- requirements
Module: mio_bus_arb

Interface
REQ-001 Parameter BURST_MAX, default 4, maximum back-to-back transfers per grant (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req/m1_req  input  1  requester wants a bus transfer this cycle (m0 = CPU, m1 = DMA/display fetch).
REQ-005 m0_addr/m1_addr  input  32  requester byte address (top nibble selects RAM/GPIO/counter/keyboard region downstream).
REQ-006 m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_wdata/m1_wdata  input  32  write data.
REQ-008 m0_gnt/m1_gnt  output  1  registered grant; at most one high in any cycle.
REQ-009 m0_ack/m1_ack  output  1  registered one-cycle pulse: the transfer issued the previous cycle completed.
REQ-010 m0_rdata/m1_rdata  output  32  read data captured with the ack; holds until the next ack to that master.
REQ-011 bus_addr  output  32  address to the memory/IO bus decoder.
REQ-012 bus_we  output  1  write strobe to the bus decoder (mem_w).
REQ-013 bus_wdata  output  32  write data to the bus (Cpu_data2bus).
REQ-014 bus_rdata  input  32  read data from the bus (Cpu_data4bus), valid combinationally in the issue cycle.
REQ-015 busy  output  1  high whenever any grant is high.

Function
REQ-016 FSM states IDLE, GNT0 and GNT1 shall exist; mN_gnt shall be high exactly while in GNTN.
REQ-017 In IDLE the block shall drive bus_addr = 0, bus_wdata = 0, bus_we = 0.
REQ-018 In GNTN, bus_addr and bus_wdata shall be muxed combinationally from master N, and bus_we shall equal mN_we & mN_req.
REQ-019 Each GNTN cycle with mN_req = 1 shall be one transfer, and the burst counter shall increment by 1 on each transfer.
REQ-020 One cycle after a transfer, mN_ack shall pulse and mN_rdata shall load the bus_rdata sampled in the issue cycle; the load happens for writes too.
REQ-021 IDLE shall leave on the first cycle any request is high; grant shall be asserted the following cycle, giving a 1-cycle request-to-grant latency.
REQ-022 On simultaneous requests, the grant shall go to the master not served last (round-robin), tracked by a 1-bit last register.
REQ-023 A grant shall end when mN_req = 0 in GNTN, or after the transfer that brings the counter to BURST_MAX.
REQ-024 At grant end, the next state shall be GNT(other) if the other master requests (no idle bubble), else GNTN again with the counter cleared if N still requests, else IDLE.
REQ-025 The burst counter shall clear on every state change, and its width shall be 4 bits, so it never wraps below BURST_MAX.
REQ-026 A master shall not receive an ack for any cycle in which it was not granted.

Reset
REQ-027 While rst is high, the block shall enter IDLE and drive gnt = 0, ack = 0, rdata = 0, counter = 0, last = 1 (m0 wins the first arbitration), busy = 0.
REQ-028 Asserting reset mid-burst shall abort the burst, and no ack shall be issued for the transfer in the reset cycle.

Configuration
REQ-029 When macro MIO_ARB_LOCK_EN is defined, inputs m0_lock/m1_lock (1 bit) shall exist, and while the granted master holds lock = 1 the BURST_MAX limit shall be ignored, with the grant ending only when req drops.
REQ-030 When MIO_ARB_LOCK_EN is undefined, the lock ports shall be absent and the BURST_MAX limit shall always apply.

Verification
REQ-031 Reset, then m0_req=1, m0_we=0, m0_addr=0x00000010, bus_rdata=0x12345678 -> m0_gnt high at cycle 1, m0_ack at cycle 2, m0_rdata=0x12345678.
REQ-032 Both requests held continuously, BURST_MAX=4 -> four m0 transfers, then four m1 transfers, alternating with no IDLE cycle between grants.
REQ-033 m1 write, addr 0xE0000000, wdata 0xA5A5A5A5 -> bus_we=1, bus_addr=0xE0000000, bus_wdata=0xA5A5A5A5 in the grant cycle, m1_ack next cycle.
REQ-034 rst asserted during the 2nd transfer of an m0 burst -> the next cycle shows IDLE, all gnt/ack 0, m0_rdata=0.
REQ-035 MIO_ARB_LOCK_EN defined, m0_lock=1, both requesting for 10 cycles -> m0 holds the grant for all 10 transfers, and m1 is granted the cycle after m0_req drops.
REQ-036 Every test: assert m0_gnt & m1_gnt never both 1, and no ack without a grant in the prior cycle.

Source files
------------

// File: rtl/mio_bus_arb.sv
// Two-master round-robin bus arbiter with bounded bursts, one-cycle acks and captured read data.
// Optional feature macro: MIO_ARB_LOCK_EN adds m0_lock/m1_lock to hold a grant past BURST_MAX.
module mio_bus_arb #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
`ifdef MIO_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                gnt0_q, gnt1_q, busy_q;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                cur_req_c, oth_req_c, lock_c, limit_c;

  // Next-state, burst accounting and combinational bus mux.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    cur_req_c = 1'b0;
    oth_req_c = 1'b0;
    lock_c    = 1'b0;

    case (state_q)
      GNT0: begin
        cur_req_c = m0_req;
        oth_req_c = m1_req;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        bus_we    = m0_we & m0_req;
        ack0_d    = m0_req;
        if (m0_req) rdata0_d = bus_rdata;
`ifdef MIO_ARB_LOCK_EN
        lock_c    = m0_lock;
`endif
      end
      GNT1: begin
        cur_req_c = m1_req;
        oth_req_c = m0_req;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        bus_we    = m1_we & m1_req;
        ack1_d    = m1_req;
        if (m1_req) rdata1_d = bus_rdata;
`ifdef MIO_ARB_LOCK_EN
        lock_c    = m1_lock;
`endif
      end
      default: ;
    endcase

    // The transfer in progress is the one that reaches the burst limit.
    limit_c = (cnt_q >= CNT_W'(BURST_MAX - 1)) && !lock_c;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_req && (!m1_req || last_q)) state_d = GNT0;
        else if (m1_req)                   state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (cur_req_c && !limit_c) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (oth_req_c)       state_d = (state_q == GNT0) ? GNT1 : GNT0;
          else if (!cur_req_c) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == GNT0) last_d = 1'b0;
    if (state_d == GNT1) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt0_q   <= (state_d == GNT0);
      gnt1_q   <= (state_d == GNT1);
      busy_q   <= (state_d != IDLE);
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_gnt   = gnt0_q;
  assign m1_gnt   = gnt1_q;
  assign busy     = busy_q;
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mio_bus_arb.sv
// Randomized + directed bench for mio_bus_arb against a transaction-level arbitration model.
module tb_mio_bus_arb;

  localparam int unsigned BURST_MAX = 4;
`ifdef MIO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
`ifdef MIO_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: current owner (-1 = none), transfers in this grant, last served master.
  int          mg;
  int          mcnt;
  int          mlast;
  logic        mack  [2];
  logic [31:0] mrdata[2];
  logic        prev_g0, prev_g1;

  always #5 clk = ~clk;

  mio_bus_arb #(.BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
`ifdef MIO_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mg = -1; mcnt = 0; mlast = 1;
    mack[0] = 1'b0; mack[1] = 1'b0;
    mrdata[0] = '0; mrdata[1] = '0;
    prev_g0 = 1'b0; prev_g1 = 1'b0;
  endtask

  // Drive one cycle of inputs, check outputs, advance the model, step the clock.
  task automatic cycle(input logic r, input logic q0, input logic q1,
                       input logic w0, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] rd, input logic lk0, input logic lk1);
    logic        q[2];
    logic        lk[2];
    logic [31:0] ea, ed;
    logic        ew, req_now, done;
    int          o;
    rst = r; m0_req = q0; m1_req = q1; m0_we = w0; m1_we = w1;
    m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1; bus_rdata = rd;
`ifdef MIO_ARB_LOCK_EN
    m0_lock = lk0; m1_lock = lk1;
`endif
    q[0] = q0; q[1] = q1;
    lk[0] = lk0 & LOCK_EN; lk[1] = lk1 & LOCK_EN;
    #1;
    ea = '0; ed = '0; ew = 1'b0;
    if (mg == 0) begin ea = a0; ed = d0; ew = w0 & q0; end
    if (mg == 1) begin ea = a1; ed = d1; ew = w1 & q1; end
    chk("m0_gnt", 32'(m0_gnt), 32'(mg == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(mg == 1));
    chk("busy", 32'(busy), 32'(mg >= 0));
    chk("bus_addr", bus_addr, ea);
    chk("bus_wdata", bus_wdata, ed);
    chk("bus_we", 32'(bus_we), 32'(ew));
    chk("m0_ack", 32'(m0_ack), 32'(mack[0]));
    chk("m1_ack", 32'(m1_ack), 32'(mack[1]));
    chk("m0_rdata", m0_rdata, mrdata[0]);
    chk("m1_rdata", m1_rdata, mrdata[1]);
    chk("gnt_both", 32'(m0_gnt & m1_gnt), 32'd0);
    chk("ack0_no_gnt", 32'(m0_ack & ~prev_g0), 32'd0);
    chk("ack1_no_gnt", 32'(m1_ack & ~prev_g1), 32'd0);
    prev_g0 = m0_gnt; prev_g1 = m1_gnt;

    if (r) begin
      model_reset();
    end else begin
      mack[0] = 1'b0; mack[1] = 1'b0;
      if (mg >= 0 && q[mg]) begin
        mack[mg] = 1'b1;
        mrdata[mg] = rd;
      end
      if (mg < 0) begin
        if (q0 && q1)  mg = (mlast == 1) ? 0 : 1;
        else if (q0)   mg = 0;
        else if (q1)   mg = 1;
        if (mg >= 0) begin mlast = mg; mcnt = 0; end
      end else begin
        req_now = q[mg];
        if (req_now) mcnt++;
        done = !req_now || (!lk[mg] && mcnt >= int'(BURST_MAX));
        if (done) begin
          mcnt = 0;
          o = 1 - mg;
          if (q[o]) begin mg = o; mlast = o; end
          else if (!req_now) mg = -1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle(input logic r);
    cycle(r, 0, 0, 0, 0, '0, '0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; bus_rdata = '0;
`ifdef MIO_ARB_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    idle_cycle(1'b1);

    // Single m0 read: grant one cycle after request, ack the cycle after.
    for (int i = 0; i < 2; i++)
      cycle(0, 1, 0, 0, 0, 32'h10, '0, '0, '0, 32'h12345678, 0, 0);
    idle_cycle(1'b0);
    chk("req031_rdata", m0_rdata, 32'h12345678);

    // Both requesting from reset: alternating 4-transfer bursts, never idle.
    idle_cycle(1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 1, 0, 0, 32'(i), 32'(100 + i), '0, '0, $urandom, 0, 0);
      if (i >= 1) busy_cnt += int'(busy);
    end
    chk("req032_busy_run", 32'(busy_cnt), 32'd16);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // m1 write to the keyboard region.
    for (int i = 0; i < 2; i++)
      cycle(0, 0, 1, 0, 1, '0, 32'hE0000000, '0, 32'hA5A5A5A5, 32'h5, 0, 0);
    idle_cycle(1'b0);
    chk("req033_m1_rdata", m1_rdata, 32'h5);

    // Reset during the second transfer of an m0 burst.
    cycle(0, 1, 0, 0, 0, 32'h20, '0, '0, '0, 32'hDEAD0001, 0, 0);
    cycle(0, 1, 0, 0, 0, 32'h24, '0, '0, '0, 32'hDEAD0002, 0, 0);
    cycle(1, 1, 0, 0, 0, 32'h28, '0, '0, '0, 32'hDEAD0003, 0, 0);
    chk("req034_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("req034_m0_ack", 32'(m0_ack), 32'd0);
    chk("req034_m0_rdata", m0_rdata, 32'd0);
    idle_cycle(1'b0);

`ifdef MIO_ARB_LOCK_EN
    // Locked m0 keeps the bus past the burst limit; m1 follows when m0 drops.
    for (int i = 0; i < 11; i++)
      cycle(0, 1, 1, 0, 0, 32'(i), '0, '0, '0, $urandom, 1, 0);
    chk("req035_m0_held", 32'(m0_gnt), 32'd1);
    cycle(0, 0, 1, 0, 0, '0, '0, '0, '0, '0, 0, 0);
    chk("req035_m1_gnt", 32'(m1_gnt), 32'd1);
    idle_cycle(1'b1);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
            1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
            $urandom, ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
